// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared FP32 types for the multiplier scheduler and its result FIFO.
//   fp32_t   : raw IEEE-754 single-precision bit pattern
//   rmode_e  : rounding-mode encodings understood by the fp_mul core
//   wrap_inc : circular-pointer increment helper
// ----------------------------------------------------------------------------
package fpu_pkg;

    localparam int FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rmode_e;

    // Next index of a circular buffer of n entries.
    function automatic int wrap_inc(input int v, input int n);
        return (v == n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fp_mul_resp_fifo.sv
// ----------------------------------------------------------------------------
// fp_mul_resp_fifo
// Circular-buffer FIFO holding completed multiplier results.
// A write at cycle w is visible on rd_data at w+1. rd_data reads as zero
// while empty so the response port shows clean zeros after reset.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : push wr_data (caller guarantees space, credit-protected)
//   wr_data   : payload {id, z, ovrf, udrf}
//   rd_en     : pop the head entry
//   rd_data   : head entry (zero when empty)
//   empty     : no entries stored
//   full      : DEPTH entries stored
// ----------------------------------------------------------------------------
module fp_mul_resp_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_rd = rd_en && !empty;
        // A write into a full buffer is only accepted when the head leaves
        // in the same cycle (the slot being written is the one being freed).
        do_wr = wr_en && (!full || do_rd);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = PTR_W'(wrap_inc(int'(wr_ptr_q), DEPTH));
        end
        if (do_rd) begin
            rd_ptr_d = PTR_W'(wrap_inc(int'(rd_ptr_q), DEPTH));
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && full && !rd_en));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(rd_en && empty));

endmodule

// File: rtl/fp_mul_sched.sv
// ----------------------------------------------------------------------------
// fp_mul_sched
// Shares one fixed-latency pipelined FP32 multiplier core among N_REQ
// requesters. A round-robin arbiter grants one request per cycle while
// credits remain, the issue register drives the core, a LAT-deep tag pipe
// carries the requester id alongside the core pipeline, and completed
// results land in a credit-protected FIFO feeding a single response port.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : per-requester handshake (ready one-hot)
//   req_x, req_y, req_rmode       : packed per-requester operands / rmode
//   core_valid/x/y/rmode          : registered issue to the core
//   core_z, core_ovrf, core_udrf  : core result, LAT cycles after issue
//   resp_valid/ready              : response handshake (FIFO head)
//   resp_id, resp_z, resp_ovrf/udrf : head result and originating requester
// ----------------------------------------------------------------------------
module fp_mul_sched
    import fpu_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int LAT    = 3,
    parameter int FIFO_D = 4,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*FP_W-1:0] req_x,
    input  logic [N_REQ*FP_W-1:0] req_y,
    input  logic [N_REQ*3-1:0]    req_rmode,
    output logic                  core_valid,
    output logic [FP_W-1:0]       core_x,
    output logic [FP_W-1:0]       core_y,
    output logic [2:0]            core_rmode,
    input  logic [FP_W-1:0]       core_z,
    input  logic                  core_ovrf,
    input  logic                  core_udrf,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [FP_W-1:0]       resp_z,
    output logic                  resp_ovrf,
    output logic                  resp_udrf
);

    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam int PL_W  = ID_W + FP_W + 2;

    // Unpacked per-requester views of the flat operand buses.
    fp32_t      req_x_arr  [N_REQ];
    fp32_t      req_y_arr  [N_REQ];
    logic [2:0] req_rm_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_x_arr[gi]  = req_x[gi*FP_W +: FP_W];
        assign req_y_arr[gi]  = req_y[gi*FP_W +: FP_W];
        assign req_rm_arr[gi] = req_rmode[gi*3 +: 3];
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    logic             can_issue;
    logic             pop;

    logic             core_valid_q, core_valid_d;
    fp32_t            core_x_q, core_x_d;
    fp32_t            core_y_q, core_y_d;
    logic [2:0]       core_rmode_q, core_rmode_d;
    logic [ID_W-1:0]  core_id_q, core_id_d;

    logic             tag_v_q  [LAT];
    logic             tag_v_d  [LAT];
    logic [ID_W-1:0]  tag_id_q [LAT];
    logic [ID_W-1:0]  tag_id_d [LAT];

    logic             fifo_empty, fifo_full;
    logic [PL_W-1:0]  fifo_wr_data, fifo_rd_data;

    // cnt counts every op between grant and pop, so it bounds FIFO usage.
    assign can_issue = (cnt_q < CNT_W'(FIFO_D));
    assign pop       = resp_valid && resp_ready;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        if (can_issue) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % N_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_id  = ID_W'(idx);
                end
            end
        end
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = grant_any ? grant_id : rr_ptr_q;

        cnt_d = cnt_q;
        if (grant_any && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!grant_any && pop) begin
            cnt_d = cnt_q - 1'b1;
        end

        // Operand registers hold their last value when idle.
        core_valid_d = grant_any;
        core_x_d     = core_x_q;
        core_y_d     = core_y_q;
        core_rmode_d = core_rmode_q;
        core_id_d    = core_id_q;
        if (grant_any) begin
            core_x_d     = req_x_arr[grant_id];
            core_y_d     = req_y_arr[grant_id];
            core_rmode_d = req_rm_arr[grant_id];
            core_id_d    = grant_id;
        end

        // Tag pipe stage i lines up with core pipeline stage i, so the last
        // stage is valid exactly when core_z carries that op's product.
        tag_v_d[0]  = core_valid_q;
        tag_id_d[0] = core_id_q;
        for (int i = 1; i < LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            rr_ptr_q     <= ID_W'(N_REQ - 1);
            core_valid_q <= 1'b0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            core_rmode_q <= '0;
            core_id_q    <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_v_q[i]  <= 1'b0;
                tag_id_q[i] <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            core_valid_q <= core_valid_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            core_rmode_q <= core_rmode_d;
            core_id_q    <= core_id_d;
            for (int i = 0; i < LAT; i++) begin
                tag_v_q[i]  <= tag_v_d[i];
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

    assign core_valid = core_valid_q;
    assign core_x     = core_x_q;
    assign core_y     = core_y_q;
    assign core_rmode = core_rmode_q;

    assign fifo_wr_data = {tag_id_q[LAT-1], core_z, core_ovrf, core_udrf};

    fp_mul_resp_fifo #(
        .DEPTH (FIFO_D),
        .W     (PL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tag_v_q[LAT-1]),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign resp_valid = !fifo_empty;
    assign {resp_id, resp_z, resp_ovrf, resp_udrf} = fifo_rd_data;

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= CNT_W'(FIFO_D));
    a_fifo_space: assert property (@(posedge clk) disable iff (rst)
        !(tag_v_q[LAT-1] && fifo_full && !pop));
    a_resp_stable: assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !resp_ready) |=>
            (resp_valid && $stable({resp_id, resp_z, resp_ovrf, resp_udrf})));

endmodule
